// File: rtl/fp16_pkg.sv
// Shared fp16 format constants, accumulator state encoding and classification helpers.
package fp16_pkg;
   localparam int FLOAT_LEN = 16;
   localparam int EXP_LEN   = 5;
   localparam int MANT_LEN  = 10;

   localparam logic [FLOAT_LEN-1:0] FP16_ZERO = 16'h0000;
   localparam logic [FLOAT_LEN-1:0] FP16_PINF = 16'h7C00;
   localparam logic [FLOAT_LEN-1:0] FP16_QNAN = 16'h7E00;

   typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_t;

   function automatic logic fp16_is_nan(input logic [FLOAT_LEN-1:0] x);
      return (&x[MANT_LEN +: EXP_LEN]) && (|x[MANT_LEN-1:0]);
   endfunction

   function automatic logic fp16_is_inf(input logic [FLOAT_LEN-1:0] x);
      return (&x[MANT_LEN +: EXP_LEN]) && !(|x[MANT_LEN-1:0]);
   endfunction
endpackage

// File: rtl/float16_adder.sv
// Combinational fp16 adder: align, add/subtract, normalise, round-to-nearest-even,
// with subnormal, infinity and NaN handling.
module float16_adder
   import fp16_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);
   logic        swap, eff_sub, any_nan, a_inf, b_inf;
   logic [15:0] big, sml;
   logic [4:0]  e_big, e_sml, d;
   logic [3:0]  d_c;
   logic [10:0] m_big, m_sml;
   logic [27:0] sh;
   logic [13:0] big14, sml14;
   logic [14:0] s;
   logic [6:0]  e;
   logic [10:0] mant;
   logic [11:0] r;
   logic        rnd_up;

   always_comb begin
      any_nan = fp16_is_nan(a) || fp16_is_nan(b);
      a_inf   = fp16_is_inf(a);
      b_inf   = fp16_is_inf(b);
      eff_sub = a[15] ^ b[15];
      swap    = b[14:0] > a[14:0];
      big     = swap ? b : a;
      sml     = swap ? a : b;
      e_big   = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
      e_sml   = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
      m_big   = {big[14:10] != 5'd0, big[9:0]};
      m_sml   = {sml[14:10] != 5'd0, sml[9:0]};
      d       = e_big - e_sml;
      // A shift of 15 already pushes every smaller-operand bit into the sticky region.
      d_c     = (d > 5'd15) ? 4'd15 : d[3:0];
      sh      = {m_sml, 17'd0} >> d_c;
      big14   = {m_big, 3'b000};
      sml14   = {sh[27:15], sh[14] | (|sh[13:0])};
      s       = eff_sub ? ({1'b0, big14} - {1'b0, sml14}) : ({1'b0, big14} + {1'b0, sml14});
      e       = {2'b00, e_big};

      if (s[14]) begin
         s = {1'b0, s[14:2], s[1] | s[0]};
         e = e + 7'd1;
      end else begin
         for (int i = 0; i < 14; i++) begin
            if (s != 15'd0 && !s[13] && e > 7'd1) begin
               s = s << 1;
               e = e - 7'd1;
            end
         end
      end

      mant   = s[13:3];
      rnd_up = s[2] && ((|s[1:0]) || mant[0]);
      r      = {1'b0, mant} + {11'd0, rnd_up};
      if (r[11]) begin
         r = r >> 1;
         e = e + 7'd1;
      end

      if (any_nan || (a_inf && b_inf && eff_sub))
         sum = FP16_QNAN;
      else if (a_inf)
         sum = a;
      else if (b_inf)
         sum = b;
      else if (e >= 7'd31)
         sum = {big[15], FP16_PINF[14:0]};
      else if (r == 12'd0 && eff_sub)
         sum = FP16_ZERO;
      else
         sum = {big[15], r[10] ? e[4:0] : 5'd0, r[9:0]};
   end
endmodule

// File: rtl/fp16_accumulator.sv
// Sequential fp16 vector sum: folds cfg_len handshaked operands into a running
// sum and presents the result with sticky overflow/NaN flags.
module fp16_accumulator #(
   parameter int FLOAT_LEN = 16,
   parameter int EXP_LEN   = 5,
   parameter int MANT_LEN  = 10,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     cfg_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FLOAT_LEN-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FLOAT_LEN-1:0] out_data,
   output logic                 out_ovf,
   output logic                 out_nan,
   output logic                 busy
);
   import fp16_pkg::*;

   acc_state_t              state;
   logic [CNT_W-1:0]        len_q;
   logic [CNT_W-1:0]        cnt;
   logic [FLOAT_LEN-1:0]    acc;
   logic [EXP_LEN+MANT_LEN:0] sum;
   logic                    ovf, nan;

   float16_adder u_adder (
      .a   (acc),
      .b   (in_data),
      .sum (sum)
   );

   assign in_ready  = (state == ACC);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = acc;
   assign out_ovf   = ovf;
   assign out_nan   = nan;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         len_q <= '0;
         cnt   <= '0;
         acc   <= FP16_ZERO;
         ovf   <= 1'b0;
         nan   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_q <= cfg_len;
                  cnt   <= '0;
                  acc   <= FP16_ZERO;
                  ovf   <= 1'b0;
                  nan   <= 1'b0;
                  state <= (cfg_len == '0) ? DONE : ACC;
               end
            end
            ACC: begin
               if (in_valid) begin
                  acc <= sum;
                  cnt <= cnt + 1'b1;
                  ovf <= ovf | fp16_is_inf(sum);
                  nan <= nan | fp16_is_nan(in_data) | fp16_is_nan(sum);
                  if (cnt == len_q - 1'b1)
                     state <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed bench for fp16_accumulator; inputs change and outputs are sampled on the falling edge.
module tb_fp16_accumulator;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  cfg_len;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_ovf;
   logic        out_nan;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fp16_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .out_nan   (out_nan),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_vec(input logic [7:0] len);
      start   = 1'b1;
      cfg_len = len;
      @(negedge clk);
      start   = 1'b0;
      cfg_len = 8'd0;
   endtask

   task automatic beat(input logic [15:0] x);
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_after_hs_valid"}, out_valid, 1'b0);
      chk({tag, "_after_hs_busy"}, busy, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_ovf"}, out_ovf, 1'b0);
      chk({tag, "_nan"}, out_nan, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_data"}, out_data, 16'h0000);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cfg_len = 8'd0;
      in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // 1.0 + 2.0 + 0.5 with back-to-back beats
      start_vec(8'd3);
      chk("t1_busy", busy, 1'b1);
      chk("t1_in_ready", in_ready, 1'b1);
      beat(16'h3C00);
      beat(16'h4000);
      chk("t1_early_valid", out_valid, 1'b0);
      beat(16'h3800);
      in_valid = 1'b0;
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_data", out_data, 16'h4300);
      chk("t1_ovf", out_ovf, 1'b0);
      chk("t1_nan", out_nan, 1'b0);
      chk("t1_in_ready_done", in_ready, 1'b0);
      handshake("t1");

      // max finite + max finite overflows to +inf
      start_vec(8'd2);
      beat(16'h7BFF);
      beat(16'h7BFF);
      in_valid = 1'b0;
      chk("t2_valid", out_valid, 1'b1);
      chk("t2_data", out_data, 16'h7C00);
      chk("t2_ovf", out_ovf, 1'b1);
      chk("t2_nan", out_nan, 1'b0);
      handshake("t2");

      // NaN input is sticky until the handshake
      start_vec(8'd2);
      beat(16'h7E00);
      beat(16'h3C00);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_valid", out_valid, 1'b1);
         chk("t3_nan", out_nan, 1'b1);
         chk("t3_data_is_nan", (out_data[14:10] == 5'h1F) && (out_data[9:0] != 10'd0), 1'b1);
         @(negedge clk);
      end
      handshake("t3");

      // zero-length vector
      start_vec(8'd0);
      chk("t4_valid", out_valid, 1'b1);
      chk("t4_in_ready", in_ready, 1'b0);
      chk("t4_data", out_data, 16'h0000);
      chk("t4_busy", busy, 1'b1);
      handshake("t4");

      // gapped input, stray start in ACC, output stall, start during handshake
      start_vec(8'd4);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            in_valid = 1'b0;
            if (i == 2) begin
               start   = 1'b1;
               cfg_len = 8'd0;
            end
            @(negedge clk);
            start = 1'b0;
            chk("t5_gap_valid", out_valid, 1'b0);
            chk("t5_gap_in_ready", in_ready, 1'b1);
         end
         beat(16'h3C00);
      end
      in_valid = 1'b1;
      in_data  = 16'h4000;
      for (int i = 0; i < 5; i++) begin
         chk("t5_stall_valid", out_valid, 1'b1);
         chk("t5_stall_data", out_data, 16'h4400);
         chk("t5_stall_in_ready", in_ready, 1'b0);
         chk("t5_stall_flags", {out_ovf, out_nan}, 2'b00);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      start     = 1'b1;
      cfg_len   = 8'd1;
      out_ready = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      chk("t5_hs_start_ignored", busy, 1'b0);
      chk("t5_hs_valid", out_valid, 1'b0);

      // reset mid-vector, then a fresh one-beat vector
      start_vec(8'd4);
      beat(16'h3C00);
      beat(16'h3C00);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      chk_all_zero("t6_rst");
      @(negedge clk);
      chk("t6_idle_busy", busy, 1'b0);
      start_vec(8'd1);
      beat(16'h4200);
      in_valid = 1'b0;
      chk("t6_valid", out_valid, 1'b1);
      chk("t6_data", out_data, 16'h4200);
      chk("t6_flags", {out_ovf, out_nan}, 2'b00);
      handshake("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fp16_accumulator.md
# fp16_accumulator

Sequential vector-sum stage built on the combinational `float16_adder`. It accepts a stream of `cfg_len` fp16 operands over a valid/ready handshake and folds each one into a running sum. It then presents the final fp16 sum, with sticky overflow/NaN flags, on a valid/ready output port. It sits between the activation accelerator's operand stream and the downstream normalisation stage, and is the adder's direct consumer.

## Interface
- `FLOAT_LEN`, 16, operand/result width
- `EXP_LEN`, 5, exponent width
- `MANT_LEN`, 10, mantissa width
- `CNT_W`, 8, width of the length register and beat counter
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `start`  in  1  one-cycle request to begin a vector; honoured only in IDLE
- `cfg_len`  in  CNT_W  operand count, sampled on an accepted `start`
- `in_valid`  in  1  operand valid
- `in_ready`  out  1  operand accept; high only in ACC
- `in_data`  in  FLOAT_LEN  fp16 operand
- `out_valid`  out  1  result valid; high only in DONE
- `out_ready`  in  1  consumer accept
- `out_data`  out  FLOAT_LEN  fp16 sum
- `out_ovf`  out  1  sticky: some adder result had exp=0x1F, mant=0 during this vector
- `out_nan`  out  1  sticky: some input or adder result was NaN (exp=0x1F, mant≠0)
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE + `start`:
  - Latch `len_q ← cfg_len`, `acc ← 0x0000`, `cnt ← 0`, clear both flags.
  - If `cfg_len == 0`, go to DONE; otherwise go to ACC.
- ACC:
  - `in_ready = 1`. A beat is taken when `in_valid & in_ready`.
  - On each beat: `acc ← float16_adder(a=acc, b=in_data)`, `cnt ← cnt + 1`.
  - Flags update from `in_data` and from the adder result of that beat.
  - The beat with `cnt == len_q − 1` goes to DONE.
- DONE:
  - `out_valid = 1`, `out_data = acc`; `out_ovf` and `out_nan` are held.
  - On `out_valid & out_ready`, go to IDLE.
- Summation is strictly sequential in arrival order; no reassociation. Bit-exactness against a host float reference is not required.
- `start` outside IDLE is ignored and not queued. `cfg_len` changes after acceptance have no effect.
- Once inf/NaN enters `acc`, accumulation continues; the result is whatever the adder yields, and the flags remain set.
- Width rules: `cnt` never exceeds `len_q`, so no wrap handling is needed. The maximum vector length is 2^CNT_W − 1.

## Timing
- Reset values (whole cycle with `rst_n = 0`): state IDLE; `in_ready`, `out_valid`, `out_ovf`, `out_nan`, `busy` all 0; `out_data`, `acc`, `cnt`, `len_q` all 0.
- Reset mid-vector: return to IDLE on the next edge. The partial sum and flags are discarded and no output is produced.
- `busy` rises the cycle after an accepted `start`.
- The adder path is combinational. One beat per cycle is sustained with `in_valid` held high.
- Latency: `out_valid` rises the cycle after the last beat is accepted. For `cfg_len == 0`, it rises the cycle after `start`.
- Backpressure: while `out_ready = 0`, `out_valid`, `out_data` and the flags hold stable.
- `in_ready` is low in IDLE and DONE, so extra input beats stall upstream.
- `start` on the same cycle as the output handshake is ignored; the FSM is still in DONE on that cycle. Earliest restart is the next cycle.

## Structure
- Shared package `fp16_pkg` holds:
  - `FLOAT_LEN`/`EXP_LEN`/`MANT_LEN` constants;
  - the `acc_state_t` enum {IDLE, ACC, DONE};
  - helper functions `fp16_is_nan`, `fp16_is_inf`;
  - constants `FP16_ZERO = 0x0000`, `FP16_PINF = 0x7C00`.
- One sub-module: `float16_adder`, instantiated unchanged with `a = acc`, `b = in_data`.
- The FSM, counter and flags live in this module.

## Test plan
- `cfg_len=3`; beats 0x3C00, 0x4000, 0x3800 (1.0, 2.0, 0.5), `in_valid` always high → `out_data=0x4300` (3.5), flags 0, `out_valid` the cycle after the third beat.
- `cfg_len=2`; beats 0x7BFF, 0x7BFF → `out_data=0x7C00`, `out_ovf=1`, `out_nan=0`.
- `cfg_len=2`; beats 0x7E00, 0x3C00 → `out_nan=1`, and it holds until the handshake.
- `cfg_len=0` → `out_valid` one cycle after `start`, `out_data=0x0000`, no `in_ready` pulse.
- `cfg_len=4` with `in_valid` toggled every other cycle; `out_ready` held low 5 cycles in DONE; `start` pulsed during ACC → sum of 4×0x3C00 = 0x4400, outputs stable across the stall, stray `start` ignored.
- `cfg_len=4`; `rst_n` low for one cycle after 2 beats → IDLE next cycle, all outputs 0. A new `start` with `cfg_len=1` and beat 0x4200 → `out_data=0x4200`.
